// File: rtl/rename_map_pkg.sv
// Shared types and constants for the rename stage: register index types, the uop record,
// free-list reset image and a popcount helper.
package rename_map_pkg;

    localparam int LOG_RF_DEPTH = 32;
    localparam int PHY_RF_DEPTH = 128;
    localparam int LA = $clog2(LOG_RF_DEPTH);
    localparam int PA = $clog2(PHY_RF_DEPTH);

    typedef logic [PA-1:0] phys_reg_t;
    typedef logic [LA-1:0] log_reg_t;

    localparam phys_reg_t PHY_ZERO = '0;

    // Register fields are physical-width; on the input side only the low LA bits carry the
    // logical index, and the stage rewrites them with physical indices.
    typedef struct packed {
        logic [31:0] pc;
        logic [6:0]  opcode;
        logic [2:0]  funct3;
        logic        rd_valid;
        phys_reg_t   rd;
        logic        rs1_valid;
        phys_reg_t   rs1;
        logic        rs2_valid;
        phys_reg_t   rs2;
    } uop_t;

    // Physical registers 0..LOG_RF_DEPTH-1 start out holding the identity mapping.
    localparam logic [PHY_RF_DEPTH-1:0] RESET_FREE =
        {{(PHY_RF_DEPTH-LOG_RF_DEPTH){1'b1}}, {LOG_RF_DEPTH{1'b0}}};
    localparam logic [PA:0] RESET_NUM_FREE = (PA+1)'(PHY_RF_DEPTH - LOG_RF_DEPTH);

    function automatic logic [PA:0] popcount(input logic [PHY_RF_DEPTH-1:0] v);
        logic [PA:0] n;
        n = '0;
        for (int i = 0; i < PHY_RF_DEPTH; i++) begin
            n = n + (PA+1)'(v[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/rename_map_free_list.sv
// Bitmap free list: lowest-free-index allocation, incrementally kept free count, and a
// one-cycle reload of the whole bitmap on flush.
module rename_map_free_list
    import rename_map_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    alloc_en,
    input  logic                    free_en,
    input  logic [PA-1:0]           free_idx,
    input  logic                    flush,
    input  logic [PHY_RF_DEPTH-1:0] reload_vec,
    output logic [PA-1:0]           alloc_idx,
    output logic [PA:0]             num_free
);

    logic [PHY_RF_DEPTH-1:0] free_vec;

    // Scanning downward leaves the lowest set bit as the final winner.
    always_comb begin
        alloc_idx = PHY_ZERO;
        for (int i = PHY_RF_DEPTH - 1; i >= 0; i--) begin
            if (free_vec[i]) begin
                alloc_idx = phys_reg_t'(i);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            free_vec <= RESET_FREE;
            num_free <= RESET_NUM_FREE;
        end else if (flush) begin
            free_vec <= reload_vec;
            num_free <= popcount(reload_vec);
        end else begin
            if (alloc_en) begin
                free_vec[alloc_idx] <= 1'b0;
            end
            if (free_en) begin
                free_vec[free_idx] <= 1'b1;
            end
            num_free <= num_free + (PA+1)'(free_en) - (PA+1)'(alloc_en);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            if (free_en) begin
                assert (!free_vec[free_idx]);
            end
            assert (num_free <= RESET_NUM_FREE);
        end
    end

endmodule

// File: rtl/rename_map.sv
// Rename stage: speculative and committed RATs, committed allocation bitmap, and the
// registered output slot between decode and dispatch.
module rename_map
    import rename_map_pkg::*;
#(
    parameter bit ZERO_REG_HARDWIRED = 1'b1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  uop_t          uop_in,
    output logic          out_valid,
    input  logic          out_ready,
    output uop_t          uop_out,
    output logic [PA-1:0] out_prd_old,
    input  logic          commit_en,
    input  logic [LA-1:0] commit_lrd,
    input  logic [PA-1:0] commit_prd,
    input  logic [PA-1:0] commit_prd_old,
    input  logic          flush,
    output logic [PA:0]   num_free,
    output logic          busy_table_wr_en,
    output logic [PA-1:0] busy_table_wr_addr,
    output logic          busy_table_data_out
);

    // Handshake: a uop moves on a cycle where valid and ready are both high on that side;
    // the output slot holds uop_out/out_prd_old stable while out_valid && !out_ready.

    logic [PA-1:0]           spec_rat     [LOG_RF_DEPTH];
    logic [PA-1:0]           cmt_rat      [LOG_RF_DEPTH];
    logic [PA-1:0]           cmt_rat_next [LOG_RF_DEPTH];
    logic [PHY_RF_DEPTH-1:0] cmt_alloc;
    logic [PHY_RF_DEPTH-1:0] cmt_alloc_next;

    logic [LA-1:0] rd_l;
    logic [LA-1:0] rs1_l;
    logic [LA-1:0] rs2_l;
    logic          needs_alloc;
    logic          fire;
    logic          alloc_en;
    logic          commit_act;
    logic [PA-1:0] alloc_idx;
    uop_t          renamed;

    assign rd_l  = uop_in.rd[LA-1:0];
    assign rs1_l = uop_in.rs1[LA-1:0];
    assign rs2_l = uop_in.rs2[LA-1:0];

    assign needs_alloc = uop_in.rd_valid && !(ZERO_REG_HARDWIRED && rd_l == '0);
    assign in_ready    = (!out_valid || out_ready) && (num_free != '0 || !needs_alloc) && !flush;
    assign fire        = in_valid && in_ready;
    assign alloc_en    = fire && needs_alloc;
    assign commit_act  = commit_en && !(ZERO_REG_HARDWIRED && commit_lrd == '0);

    assign busy_table_wr_en    = alloc_en;
    assign busy_table_wr_addr  = alloc_idx;
    assign busy_table_data_out = 1'b1;

    // Sources read the table before this cycle's rd update, so rs == rd sees the old mapping.
    always_comb begin
        renamed     = uop_in;
        renamed.rs1 = spec_rat[rs1_l];
        renamed.rs2 = spec_rat[rs2_l];
        renamed.rd  = needs_alloc ? alloc_idx : PHY_ZERO;
    end

    // Committed state with this cycle's retirement folded in; a same-cycle flush restores from it.
    always_comb begin
        cmt_alloc_next = cmt_alloc;
        for (int i = 0; i < LOG_RF_DEPTH; i++) begin
            cmt_rat_next[i] = cmt_rat[i];
        end
        if (commit_act) begin
            cmt_rat_next[commit_lrd]       = commit_prd;
            cmt_alloc_next[commit_prd]     = 1'b1;
            cmt_alloc_next[commit_prd_old] = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < LOG_RF_DEPTH; i++) begin
                cmt_rat[i] <= phys_reg_t'(i);
            end
            cmt_alloc <= ~RESET_FREE;
        end else begin
            for (int i = 0; i < LOG_RF_DEPTH; i++) begin
                cmt_rat[i] <= cmt_rat_next[i];
            end
            cmt_alloc <= cmt_alloc_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < LOG_RF_DEPTH; i++) begin
                spec_rat[i] <= phys_reg_t'(i);
            end
        end else if (flush) begin
            for (int i = 0; i < LOG_RF_DEPTH; i++) begin
                spec_rat[i] <= cmt_rat_next[i];
            end
        end else if (alloc_en) begin
            spec_rat[rd_l] <= alloc_idx;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid   <= 1'b0;
            uop_out     <= '0;
            out_prd_old <= PHY_ZERO;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (fire) begin
            out_valid   <= 1'b1;
            uop_out     <= renamed;
            out_prd_old <= needs_alloc ? spec_rat[rd_l] : PHY_ZERO;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    rename_map_free_list u_free_list (
        .clk        (clk),
        .rst        (rst),
        .alloc_en   (alloc_en),
        .free_en    (commit_act),
        .free_idx   (commit_prd_old),
        .flush      (flush),
        .reload_vec (~cmt_alloc_next),
        .alloc_idx  (alloc_idx),
        .num_free   (num_free)
    );

endmodule
